arith_arbiter: RTL

Shared sequential arithmetic unit for two requesters. It arbitrates round-robin between two add/multiply request ports, executes one operation at a time, and returns the result with the requester ID over a valid/ready response channel. Add completes in one cycle. Multiply is an iterative shift-add, so the block replaces a combinational 8x8 multiplier where area matters.

---
 rtl/arith_arbiter_if.sv | 40 ++++
 rtl/arith_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/arith_arbiter_if.sv
// Handshake bundle for arith_arbiter: two request ports, one response channel and busy.
// The arbiter connects through the slave modport and requesters through the master modport.
interface arith_arbiter_if #(
  parameter int WIDTH = 8
);
  logic               req0_valid;
  logic               req0_ready;
  logic               req0_op;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;

  logic               req1_valid;
  logic               req1_ready;
  logic               req1_op;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic               rsp_op;
  logic [2*WIDTH-1:0] rsp_result;
  logic               busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_op, rsp_result, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_op, rsp_result, busy
  );
endinterface

// File: rtl/arith_arbiter.sv
// Shared add/multiply unit for two requesters with round-robin arbitration.
// Add finishes in one cycle; multiply is a WIDTH-cycle shift-add loop.
module arith_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  arith_arbiter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]         state;
  logic               last_grant;
  logic               grant;
  logic               accept;
  logic               sel_op;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  logic               rsp_id_q;
  logic               rsp_op_q;
  logic [2*WIDTH-1:0] rsp_result_q;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    // NOTE: default assignment first so every path drives grant and no latch is inferred.
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
  end

  assign accept         = (state == S_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  assign sel_op = grant ? bus.req1_op : bus.req0_op;
  assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant ? bus.req1_b  : bus.req0_b;

  assign acc_next = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      count        <= '0;
      rsp_id_q     <= 1'b0;
      rsp_op_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the pre-edge values.
      case (state)
        S_IDLE: begin
          if (accept) begin
            last_grant <= grant;
            rsp_id_q   <= grant;
            rsp_op_q   <= sel_op;
            if (sel_op) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, sel_a};
              mplier <= sel_b;
              count  <= '0;
              state  <= S_MUL;
            end else begin
              rsp_result_q <= {{WIDTH{1'b0}}, sel_a} + {{WIDTH{1'b0}}, sel_b};
              state        <= S_RESP;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          // Always runs the full WIDTH iterations, even for zero operands.
          if (count == CW'(WIDTH - 1)) begin
            rsp_result_q <= acc_next;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = (state == S_RESP);
  assign bus.busy       = (state != S_IDLE);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_result = rsp_result_q;

endmodule
